// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: decodes format from opcode/funct3,
// extends to XLEN and buffers results in an in-order valid/ready FIFO.
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_has_imm,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam bit          IS64  = (XLEN == 64);

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_SHAMT = 3'd2;
    localparam logic [2:0] FMT_S     = 3'd3;
    localparam logic [2:0] FMT_B     = 3'd4;
    localparam logic [2:0] FMT_U     = 3'd5;
    localparam logic [2:0] FMT_J     = 3'd6;
    localparam logic [2:0] FMT_Z     = 3'd7;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_OP32   = 7'b0111011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             has_imm;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic            is_shift;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_ill;
    entry_t          dec;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    entry_t             head_q, head_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               push, pop;

    // Immediate format decode from opcode/funct3 of the incoming instruction
    always_comb begin
        opcode   = in_instr[6:0];
        f3       = in_instr[14:12];
        is_shift = (f3 == 3'b001) || (f3 == 3'b101);
        dec_imm  = '0;
        dec_fmt  = FMT_NONE;
        dec_ill  = 1'b0;
        case (opcode)
            OP_LOAD, OP_JALR: begin
                dec_fmt = FMT_I;
                dec_imm = XLEN'($signed(in_instr[31:20]));
            end
            OP_IMM: begin
                if (is_shift) begin
                    dec_fmt = FMT_SHAMT;
                    dec_imm = XLEN'(in_instr[25:20]);
                    if (!IS64 && in_instr[25]) dec_ill = 1'b1;
                    if (!((in_instr[31:26] == 6'b000000) ||
                          ((in_instr[31:26] == 6'b010000) && (f3 == 3'b101))))
                        dec_ill = 1'b1;
                end else begin
                    dec_fmt = FMT_I;
                    dec_imm = XLEN'($signed(in_instr[31:20]));
                end
            end
            OP_IMM32: begin
                if (!IS64) begin
                    dec_ill = 1'b1;
                end else if (is_shift) begin
                    dec_fmt = FMT_SHAMT;
                    dec_imm = XLEN'(in_instr[24:20]);
                end else begin
                    dec_fmt = FMT_I;
                    dec_imm = XLEN'($signed(in_instr[31:20]));
                end
            end
            OP_STORE: begin
                dec_fmt = FMT_S;
                dec_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
            end
            OP_BRANCH: begin
                dec_fmt = FMT_B;
                dec_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                         in_instr[11:8], 1'b0}));
            end
            OP_LUI, OP_AUIPC: begin
                dec_fmt = FMT_U;
                dec_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
            end
            OP_JAL: begin
                dec_fmt = FMT_J;
                dec_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                         in_instr[30:21], 1'b0}));
            end
            OP_SYSTEM: begin
                if (f3[2]) begin
                    dec_fmt = FMT_Z;
                    dec_imm = XLEN'(in_instr[19:15]);
                end
            end
            OP_OP, OP_FENCE: begin
                dec_fmt = FMT_NONE;
            end
            OP_OP32: begin
                if (!IS64) dec_ill = 1'b1;
            end
            default: begin
                dec_ill = 1'b1;
            end
        endcase
        // Illegal entries carry no immediate
        if (dec_ill) begin
            dec_fmt = FMT_NONE;
            dec_imm = '0;
        end
        dec.imm     = dec_imm;
        dec.fmt     = dec_fmt;
        dec.has_imm = (dec_fmt != FMT_NONE) && !dec_ill;
        dec.illegal = dec_ill;
        dec.tag     = in_tag;
    end

    // FIFO next state; head register tracks the entry that will be at rd_ptr
    always_comb begin
        push        = in_valid && in_ready_q;
        pop         = out_valid_q && out_ready;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        head_d      = head_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = dec;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            // New entry lands at the read slot when the FIFO drains to it this cycle
            if (count_d != '0) begin
                if (push && (rd_ptr_d == wr_ptr_q)) head_d = dec;
                else                                head_d = mem_q[rd_ptr_d];
            end
        end
        in_ready_d  = (count_d < CNT_W'(DEPTH));
        out_valid_d = (count_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            head_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
            head_q      <= head_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_imm     = head_q.imm;
    assign out_fmt     = head_q.fmt;
    assign out_has_imm = head_q.has_imm;
    assign out_illegal = head_q.illegal;
    assign out_tag     = head_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: an RV32 and an RV64 instance share stimulus.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        in_ready32, out_valid32, has32, ill32;
    logic [31:0] imm32, tag32;
    logic [2:0]  fmt32;
    logic        in_ready64, out_valid64, has64, ill64;
    logic [63:0] imm64;
    logic [31:0] tag64;
    logic [2:0]  fmt64;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] imm64;
        logic [2:0]  fmt64;
        logic        ill64;
        logic [31:0] imm32;
        logic [2:0]  fmt32;
        logic        ill32;
        logic [31:0] tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .DEPTH(2)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(imm32), .out_fmt(fmt32), .out_has_imm(has32), .out_illegal(ill32),
        .out_tag(tag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .DEPTH(2)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(imm64), .out_fmt(fmt64), .out_has_imm(has64), .out_illegal(ill64),
        .out_tag(tag64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference decode: all candidate immediates built at 64 bits, then selected
    function automatic void ref_dec(input logic [31:0] i, input bit x64,
                                    output logic [63:0] imm, output logic [2:0] fmt,
                                    output logic ill);
        logic [63:0] ii, si, bi, ui, ji, zi;
        logic [2:0]  f3;
        logic        sh;
        ii = {{52{i[31]}}, i[31:20]};
        si = {{52{i[31]}}, i[31:25], i[11:7]};
        bi = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        ui = {{32{i[31]}}, i[31:12], 12'h000};
        ji = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        zi = {59'd0, i[19:15]};
        f3 = i[14:12];
        sh = (f3 == 3'd1) || (f3 == 3'd5);
        imm = 64'd0; fmt = 3'd0; ill = 1'b0;
        case (i[6:0])
            7'h03, 7'h67: begin imm = ii; fmt = 3'd1; end
            7'h13: if (sh) begin
                imm = {58'd0, i[25:20]}; fmt = 3'd2;
                ill = (!x64 && i[25]) ||
                      !((i[31:26] == 6'h00) || (i[31:26] == 6'h10 && f3 == 3'd5));
            end else begin imm = ii; fmt = 3'd1; end
            7'h1B: if (!x64) ill = 1'b1;
                   else if (sh) begin imm = {59'd0, i[24:20]}; fmt = 3'd2; end
                   else begin imm = ii; fmt = 3'd1; end
            7'h23: begin imm = si; fmt = 3'd3; end
            7'h63: begin imm = bi; fmt = 3'd4; end
            7'h37, 7'h17: begin imm = ui; fmt = 3'd5; end
            7'h6F: begin imm = ji; fmt = 3'd6; end
            7'h73: if (f3[2]) begin imm = zi; fmt = 3'd7; end
            7'h33, 7'h0F: ;
            7'h3B: ill = !x64;
            default: ill = 1'b1;
        endcase
        if (ill) begin imm = 64'd0; fmt = 3'd0; end
    endfunction

    function automatic exp_t model(input logic [31:0] i, input logic [31:0] tg);
        exp_t e;
        logic [63:0] imm;
        logic [2:0]  f;
        logic        il;
        ref_dec(i, 1'b1, imm, f, il);
        e.imm64 = imm; e.fmt64 = f; e.ill64 = il;
        ref_dec(i, 1'b0, imm, f, il);
        e.imm32 = imm[31:0]; e.fmt32 = f; e.ill32 = il;
        e.tag = tg;
        return e;
    endfunction

    // One clock of stimulus; called #1 after a rising edge, returns #1 after the next
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] tg,
                        input logic ordy, input logic fl, output logic acc);
        exp_t e;
        logic pop;
        in_valid = v; in_instr = ins; in_tag = tg; out_ready = ordy; flush = fl;
        chk("out_valid32", out_valid32, sb.size() != 0);
        chk("out_valid64", out_valid64, sb.size() != 0);
        chk("in_ready32", in_ready32, sb.size() < 2);
        chk("in_ready64", in_ready64, sb.size() < 2);
        if (out_valid32 && sb.size() != 0) begin
            e = sb[0];
            chk("imm32", imm32, e.imm32);
            chk("fmt32", fmt32, e.fmt32);
            chk("ill32", ill32, e.ill32);
            chk("has32", has32, (e.fmt32 != 3'd0) && !e.ill32);
            chk("tag32", tag32, e.tag);
            chk("imm64", imm64, e.imm64);
            chk("fmt64", fmt64, e.fmt64);
            chk("ill64", ill64, e.ill64);
            chk("has64", has64, (e.fmt64 != 3'd0) && !e.ill64);
            chk("tag64", tag64, e.tag);
        end
        acc = v && in_ready32;
        pop = out_valid32 && ordy;
        @(posedge clk);
        #1;
        if (fl) begin
            sb.delete();
        end else begin
            if (pop && sb.size() != 0) void'(sb.pop_front());
            if (acc) sb.push_back(model(ins, tg));
        end
    endtask

    task automatic idle(input logic ordy);
        logic a;
        step(1'b0, 32'h0, 32'h0, ordy, 1'b0, a);
    endtask

    initial begin
        logic        a;
        logic [31:0] r;
        logic [6:0]  ops [16];
        ops = '{7'h03, 7'h67, 7'h13, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h37,
                7'h17, 7'h6F, 7'h73, 7'h33, 7'h3B, 7'h0F, 7'h7F, 7'h00};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", out_valid32, 1'b0);
        chk("rst_in_ready", in_ready32, 1'b0);
        chk("rst_imm32", imm32, 32'h0);
        chk("rst_imm64", imm64, 64'h0);
        chk("rst_fmt", fmt32, 3'd0);
        chk("rst_has", has64, 1'b0);
        chk("rst_ill", ill32, 1'b0);
        chk("rst_tag", tag64, 32'h0);
        @(posedge clk); #1;
        chk("rst_hold_in_ready", in_ready64, 1'b0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready32, 1'b1);

        // addi x1,x0,-1
        step(1'b1, 32'hFFF00093, 32'h100, 1'b1, 1'b0, a);
        chk("addi_valid", out_valid32, 1'b1);
        chk("addi_imm", imm32, 32'hFFFFFFFF);
        chk("addi_fmt", fmt32, 3'd1);
        chk("addi_tag", tag32, 32'h100);
        idle(1'b1);
        chk("addi_drained", out_valid32, 1'b0);

        // sw -4 then beq -8 back to back
        step(1'b1, 32'hFE112E23, 32'h104, 1'b1, 1'b0, a);
        chk("sw_imm", imm32, 32'hFFFFFFFC);
        chk("sw_fmt", fmt32, 3'd3);
        step(1'b1, 32'hFE000CE3, 32'h108, 1'b1, 1'b0, a);
        chk("beq_imm", imm32, 32'hFFFFFFF8);
        chk("beq_fmt", fmt32, 3'd4);

        // lui 0x80000
        step(1'b1, 32'h800000B7, 32'h10C, 1'b1, 1'b0, a);
        chk("lui_imm32", imm32, 32'h80000000);
        chk("lui_imm64", imm64, 64'hFFFFFFFF80000000);
        chk("lui_fmt", fmt64, 3'd5);

        // slli x1,x1,33
        step(1'b1, 32'h02109093, 32'h110, 1'b1, 1'b0, a);
        chk("slli64_imm", imm64, 64'd33);
        chk("slli64_fmt", fmt64, 3'd2);
        chk("slli64_ill", ill64, 1'b0);
        chk("slli32_ill", ill32, 1'b1);
        chk("slli32_has", has32, 1'b0);

        step(1'b1, 32'h0000007F, 32'h114, 1'b1, 1'b0, a);
        chk("bad_op_ill", ill64, 1'b1);
        chk("bad_op_imm", imm64, 64'h0);
        idle(1'b1);

        // Backpressure: third instruction held until the consumer drains
        step(1'b1, 32'h00A00513, 32'h200, 1'b0, 1'b0, a);
        step(1'b1, 32'h4050D093, 32'h204, 1'b0, 1'b0, a);
        chk("full_in_ready", in_ready32, 1'b0);
        step(1'b1, 32'h0051E073, 32'h208, 1'b0, 1'b0, a);
        chk("third_held", a, 1'b0);
        step(1'b1, 32'h0051E073, 32'h208, 1'b1, 1'b0, a);
        chk("third_still_held", a, 1'b0);
        step(1'b1, 32'h0051E073, 32'h208, 1'b1, 1'b0, a);
        chk("third_accepted", a, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Push and pop together at one entry
        step(1'b1, 32'hFF5FF0EF, 32'h300, 1'b0, 1'b0, a);
        step(1'b1, 32'h0010809B, 32'h304, 1'b1, 1'b0, a);
        chk("pp_out_valid", out_valid64, 1'b1);
        chk("pp_in_ready", in_ready64, 1'b1);
        idle(1'b1);

        // Flush with two buffered entries and a same-cycle push
        step(1'b1, 32'h00000033, 32'h400, 1'b0, 1'b0, a);
        step(1'b1, 32'h0000000F, 32'h404, 1'b0, 1'b0, a);
        step(1'b1, 32'h00100073, 32'h408, 1'b1, 1'b1, a);
        chk("flush_out_valid", out_valid32, 1'b0);
        chk("flush_in_ready", in_ready32, 1'b1);
        idle(1'b1);

        // Mixed traffic from the bench model
        for (int k = 0; k < 80; k++) begin
            r = $urandom();
            if (r[0]) r[31:26] = 6'b000000;
            step(r[1] | r[2], {r[31:7], ops[k % 16]}, 32'h1000 + 32'(k),
                 1'($urandom_range(0, 1)), 1'b0, a);
        end
        for (int k = 0; k < 3; k++) idle(1'b1);

        // Asynchronous reset in mid-stream
        step(1'b1, 32'h123450B7, 32'h500, 1'b0, 1'b0, a);
        step(1'b1, 32'h00C00067, 32'h504, 1'b0, 1'b0, a);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid32", out_valid32, 1'b0);
        chk("arst_out_valid64", out_valid64, 1'b0);
        chk("arst_in_ready", in_ready32, 1'b0);
        chk("arst_imm", imm64, 64'h0);
        sb.delete();
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        idle(1'b1);
        step(1'b1, 32'hFFF00093, 32'h600, 1'b1, 1'b0, a);
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
